bin2bcd_ctrl: RTL and testbench
===============================

# bin2bcd_ctrl

Sequencer for the 16-bit binary-to-BCD (shift-and-add-3) conversion datapath. It accepts a binary operand with a start/done/ack handshake and drives the A register's `X`, `ld`, `sh` and `ldr2` controls through one load and 16 adjust/shift iterations. It then captures the register's 4-digit `resultado` and presents it as the conversion result. It sits between the front-end that requests conversions and the A register plus its add-3 digit-correction units.

## Interface
- `N_BITS`, 16, binary operand width; equals A register input width.
- `N_DIGITS`, 4, BCD digits held in the register's upper half.
- `clk` in 1: system clock. Controller logic is posedge; all outputs are registered, so they are stable at the register's negedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: conversion request; sampled only in IDLE.
- `bin_in` in N_BITS: operand; captured on the accepted `start`.
- `ack` in 1: consumer has taken `bcd_out`; sampled only in DONE.
- `bcd_in` in 4*N_DIGITS: register `resultado`.
- `X` out N_BITS: operand to the register; holds the captured value.
- `ld` out 1: register load strobe.
- `sh` out 1: register shift strobe.
- `ldr2` out 1: register adjust-write strobe (add-3 results).
- `busy` out 1: conversion in progress.
- `done` out 1: `bcd_out` valid.
- `bcd_out` out 4*N_DIGITS: converted BCD result.
- `ovf` out 1: operand exceeds 4-digit range (see Configuration).

## Operation
- States: IDLE, LOAD, GAP, ADJ, SHIFT, DONE.
- IDLE + `start` → LOAD. `bin_in` is latched into `X`, and the bit counter and `busy` are set.
- LOAD: `ld`=1 for one cycle → GAP.
- GAP: all strobes low. This lets `resultado`, which lags A by one negedge, reflect the last write. If the counter equals N_BITS → DONE; otherwise → ADJ.
- ADJ: `ldr2`=1 for one cycle → SHIFT.
- SHIFT: `sh`=1 for one cycle; the counter increments → GAP.
- The counter runs 0..N_BITS, and exactly N_BITS ADJ/SHIFT pairs are issued. At most one of `ld`, `sh`, `ldr2` is high in any cycle.
- Entry to DONE: `bcd_in` is captured into `bcd_out`, `done`=1 and `busy`=0. `bcd_out` and `done` hold until `ack` → IDLE, at which point `done`=0 and `bcd_out` retains its value.
- `start` outside IDLE is ignored. `ack` outside DONE is ignored.
- Reset values: state IDLE; `X`, `bcd_out`, all strobes, `busy`, `done` and `ovf` are all 0.
- Reset mid-conversion: strobes drop immediately and the partial result is discarded. The next conversion is unaffected because LOAD re-initialises the register.

## Timing
- Accepted `start` is sampled at posedge 0.
- Cycle 1: LOAD.
- Cycle 2: GAP.
- Bit i (0..15): ADJ at cycle 3+3i, SHIFT at cycle 4+3i, GAP at cycle 5+3i.
- Last GAP is cycle 50. `done` rises at cycle 51, giving a latency of 51 cycles.
- `busy` is high in cycles 1–50.
- `ack` high at cycle k in DONE gives IDLE at k+1. A new `start` can be accepted at k+1 at the earliest.

## Configuration
- `BIN2BCD_OVF_CHECK_EN` defined:
  - An operand greater than 9999 is accepted, then goes IDLE → DONE directly.
  - No strobes are issued.
  - `done`=1 and `ovf`=1 at cycle 1, with `bcd_out`=16'hFFFF.
  - `ovf` clears with `ack`.
- `BIN2BCD_OVF_CHECK_EN` undefined:
  - `ovf` is tied 0.
  - Every operand runs the full sequence, and `bcd_out` is the value mod 10000 (the top digit is lost).

## Structure
- Package `bin2bcd_pkg` holds:
  - the state enum;
  - `N_BITS`, `N_DIGITS` and `BCD_MAX` (9999);
  - `BCD_OVF_CODE` (16'hFFFF);
  - the counter width, `$clog2(N_BITS+1)`.
- Natural sub-module: `bin2bcd_step_cnt`. It is the iteration counter with clear, increment and terminal-count outputs.
- The FSM and output registers stay in `bin2bcd_ctrl`.

## Test plan
The bench uses a behavioural A register with add-3 units.
- `rst_n` low mid-idle → all outputs 0. After release, no strobes until `start`.
- `bin_in`=1234, `start` → exactly 1 `ld`, 16 `ldr2` and 16 `sh` pulses, never overlapping. `done` at cycle 51 with `bcd_out`=16'h1234, held until `ack`.
- Operand range: 0 → 16'h0000; 9999 → 16'h9999. Back-to-back conversions with `ack` then `start` next cycle both succeed.
- `start` pulsed at cycles 10 and 51 (busy, DONE) → ignored. `ack` at cycle 20 → ignored, and the result is still 16'h1234.
- `rst_n` low at cycle 20 → strobes 0 immediately, `busy` 0, IDLE. Then 4321 converts to 16'h4321.
- `bin_in`=12345:
  - with `BIN2BCD_OVF_CHECK_EN`: `done`/`ovf`=1 at cycle 1, `bcd_out`=16'hFFFF, no strobes;
  - without it: `bcd_out`=16'h2345 at cycle 51, `ovf`=0.

Source files
------------

// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the binary-to-BCD conversion sequencer.
// The optional overflow check is enabled by defining BIN2BCD_OVF_CHECK_EN.
package bin2bcd_pkg;

  localparam int unsigned N_BITS   = 16;
  localparam int unsigned N_DIGITS = 4;
  localparam int unsigned BCD_W    = 4 * N_DIGITS;
  localparam int unsigned CNT_W    = $clog2(N_BITS + 1);

  localparam logic [N_BITS-1:0] BCD_MAX      = N_BITS'(9999);
  localparam logic [BCD_W-1:0]  BCD_OVF_CODE = {BCD_W{1'b1}};

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    GAP,
    ADJ,
    SHIFT,
    DONE
  } state_t;

endpackage

// File: rtl/bin2bcd_step_cnt.sv
// Iteration counter for the shift-and-add-3 sequence; saturates at N_BITS.
module bin2bcd_step_cnt
  import bin2bcd_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic tc_c
);

  logic [CNT_W-1:0] cnt;

  assign tc_c = (cnt == CNT_W'(N_BITS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !tc_c) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/bin2bcd_ctrl.sv
// Sequencer driving the A register through one load and N_BITS adjust/shift steps.
// Define BIN2BCD_OVF_CHECK_EN to reject operands above 9999 with an overflow code.
module bin2bcd_ctrl
  import bin2bcd_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [N_BITS-1:0] bin_in,
  input  logic              ack,
  input  logic [BCD_W-1:0]  bcd_in,
  output logic [N_BITS-1:0] X,
  output logic              ld,
  output logic              sh,
  output logic              ldr2,
  output logic              busy,
  output logic              done,
  output logic [BCD_W-1:0]  bcd_out,
  output logic              ovf
);

  state_t state, state_d;

  logic              accept_c;
  logic              tc_c;
  logic              ovf_op_c;
  logic              ld_d, sh_d, ldr2_d, busy_d, done_d;
  logic [N_BITS-1:0] x_d;
  logic [BCD_W-1:0]  bcd_d;

  assign accept_c = (state == IDLE) && start;

`ifdef BIN2BCD_OVF_CHECK_EN
  assign ovf_op_c = (bin_in > BCD_MAX);
`else
  assign ovf_op_c = 1'b0;
`endif

  bin2bcd_step_cnt u_step_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept_c),
    .inc   (state == SHIFT),
    .tc_c  (tc_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (start) state_d = ovf_op_c ? DONE : LOAD;
      LOAD:    state_d = GAP;
      GAP:     state_d = tc_c ? DONE : ADJ;
      ADJ:     state_d = SHIFT;
      SHIFT:   state_d = GAP;
      DONE:    if (ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered strobes line up with it.
  always_comb begin
    ld_d   = (state_d == LOAD);
    sh_d   = (state_d == SHIFT);
    ldr2_d = (state_d == ADJ);
    busy_d = (state_d == LOAD) || (state_d == GAP) || (state_d == ADJ) || (state_d == SHIFT);
    done_d = (state_d == DONE);
    x_d    = accept_c ? bin_in : X;
    bcd_d  = bcd_out;
    if ((state_d == DONE) && (state != DONE)) begin
      // Entering DONE straight from IDLE only happens for a rejected operand.
      bcd_d = (state == IDLE) ? BCD_OVF_CODE : bcd_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      X       <= '0;
      ld      <= 1'b0;
      sh      <= 1'b0;
      ldr2    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd_out <= '0;
    end else begin
      X       <= x_d;
      ld      <= ld_d;
      sh      <= sh_d;
      ldr2    <= ldr2_d;
      busy    <= busy_d;
      done    <= done_d;
      bcd_out <= bcd_d;
    end
  end

`ifdef BIN2BCD_OVF_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (accept_c && ovf_op_c) begin
      ovf <= 1'b1;
    end else if ((state == DONE) && ack) begin
      ovf <= 1'b0;
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_bin2bcd_ctrl.sv
// Bench for bin2bcd_ctrl with a behavioural A register and add-3 units on its negedge.
// Expected results come from decimal arithmetic on the operand.
module tb_bin2bcd_ctrl;

`ifdef BIN2BCD_OVF_CHECK_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b1;
  logic        start  = 1'b0;
  logic        ack    = 1'b0;
  logic [15:0] bin_in = '0;
  logic [15:0] bcd_in;
  logic [15:0] X;
  logic [15:0] bcd_out;
  logic        ld, sh, ldr2, busy, done, ovf;

  int n_cmp = 0;
  int n_err = 0;
  int n_ld = 0, n_sh = 0, n_ldr2 = 0, n_ovl = 0;

  logic [31:0] a_reg     = '0;
  logic [15:0] resultado = '0;

  assign bcd_in = resultado;

  always #5 clk = ~clk;

  bin2bcd_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bin_in  (bin_in),
    .ack     (ack),
    .bcd_in  (bcd_in),
    .X       (X),
    .ld      (ld),
    .sh      (sh),
    .ldr2    (ldr2),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out),
    .ovf     (ovf)
  );

  function automatic logic [31:0] add3(input logic [31:0] a);
    logic [31:0] r;
    logic [3:0]  d;
    r = a;
    for (int i = 0; i < 4; i++) begin
      d = r[16 + 4*i +: 4];
      if (d >= 4'd5) d = d + 4'd3;
      r[16 + 4*i +: 4] = d;
    end
    return r;
  endfunction

  function automatic logic [15:0] ref_bcd(input int v);
    int m;
    m = v % 10000;
    return {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  // A register and its one-negedge-late resultado copy, plus strobe accounting.
  always @(negedge clk) begin
    resultado <= a_reg[31:16];
    if (ld)        a_reg <= {16'h0, X};
    else if (ldr2) a_reg <= add3(a_reg);
    else if (sh)   a_reg <= a_reg << 1;
    n_ld   <= n_ld + int'(ld);
    n_sh   <= n_sh + int'(sh);
    n_ldr2 <= n_ldr2 + int'(ldr2);
    if ((int'(ld) + int'(sh) + int'(ldr2)) > 1) n_ovl <= n_ovl + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called just after a negedge; returns just after a negedge with the DUT back in IDLE.
  task automatic convert(input int v, input bit junk);
    logic [15:0] ev;
    bit          eo;
    int          el, cyc, bad;
    int          b_ld, b_sh, b_r2, b_ov;
    eo   = OVF_EN && (v > 9999);
    ev   = eo ? 16'hFFFF : ref_bcd(v);
    el   = eo ? 1 : 51;
    b_ld = n_ld; b_sh = n_sh; b_r2 = n_ldr2; b_ov = n_ovl;
    bin_in = 16'(v);
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    bad   = 0;
    while (!done && cyc < 200) begin
      if (busy !== 1'b1 || cyc > 50) bad++;
      start = junk && (cyc == 10);
      ack   = junk && (cyc == 20);
      if (junk) bin_in = 16'($urandom);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    ack   = 1'b0;
    check("latency", 64'(cyc), 64'(el));
    check("busy_window", 64'(bad), 64'(0));
    check("done", 64'(done), 64'(1));
    check("busy_in_done", 64'(busy), 64'(0));
    check("bcd_out", 64'(bcd_out), 64'(ev));
    check("ovf", 64'(ovf), 64'(eo));
    if (junk) begin
      start  = 1'b1;
      bin_in = 16'($urandom);
      @(negedge clk);
      start = 1'b0;
    end
    repeat ($urandom_range(0, 3)) @(negedge clk);
    check("hold_done", 64'(done), 64'(1));
    check("hold_bcd", 64'(bcd_out), 64'(ev));
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check("ack_done", 64'(done), 64'(0));
    check("ack_bcd_kept", 64'(bcd_out), 64'(ev));
    check("ack_ovf", 64'(ovf), 64'(0));
    check("n_ld", 64'(n_ld - b_ld), 64'(eo ? 0 : 1));
    check("n_sh", 64'(n_sh - b_sh), 64'(eo ? 0 : 16));
    check("n_ldr2", 64'(n_ldr2 - b_r2), 64'(eo ? 0 : 16));
    check("overlap", 64'(n_ovl - b_ov), 64'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check(tag, 64'({X, bcd_out, ld, sh, ldr2, busy, done, ovf}), 64'(0));
  endtask

  initial begin
    int b_ld, b_sh, b_r2;
    int v;

    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("por_outputs");
    rst_n = 1'b1;
    @(negedge clk);

    convert(1234, 1'b0);

    // Reset while idle clears a held result; nothing moves until start.
    rst_n = 1'b0;
    #1;
    check_reset_outputs("idle_rst_outputs");
    @(negedge clk);
    rst_n = 1'b1;
    b_ld = n_ld; b_sh = n_sh; b_r2 = n_ldr2;
    repeat (6) @(negedge clk);
    check("idle_no_strobes", 64'((n_ld - b_ld) + (n_sh - b_sh) + (n_ldr2 - b_r2)), 64'(0));
    check("idle_busy", 64'(busy), 64'(0));

    convert(0, 1'b0);
    convert(9999, 1'b0);
    convert(1234, 1'b1);

    // Reset in the middle of a conversion.
    bin_in = 16'd777;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_strobes", 64'({ld, sh, ldr2}), 64'(0));
    check("midrst_busy_done", 64'({busy, done}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    convert(4321, 1'b0);

    convert(12345, 1'b0);

    for (int i = 0; i < 12; i++) begin
      v = (i % 2 == 0) ? int'($urandom_range(0, 9999)) : int'($urandom_range(0, 65535));
      convert(v, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
